// File: rtl/aes_ks_pkg.sv
// Shared types and helpers for the iterative AES key-schedule engine.
// No logic of its own; functions are combinational and synthesizable.
// Holds the FSM state enum, GF(2^8) helpers, the S-box, NK legality and size helpers.
package aes_ks_pkg;

    // Upper bounds over all legal key sizes (AES-256).
    localparam int NR_MAX    = 14;
    localparam int WORDS_MAX = 4 * (NR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KEYW,
        S_GEN,
        S_SUB,      // S-box lookup presented
        S_SUB_WR,   // S-box result consumed, word written
        S_FLUSH,
        S_REPLAY
    } ks_state_t;

    function automatic bit nk_legal(input int nk);
        return (nk == 4) || (nk == 6) || (nk == 8);
    endfunction

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic int total_words(input int nk);
        return 4 * (nr_of(nk) + 1);
    endfunction

    // Words that need SubWord: every NK-th word, plus the mid-group word for AES-256.
    function automatic logic is_sbox_word(input int i, input int nk);
        return ((i % nk) == 0) || ((nk == 8) && ((i % nk) == 4));
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as the GF(2^8) inverse (x^254) followed by the affine map,
    // which avoids a 256-entry table; 0 maps to 0 before the affine step.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int k = 0; k < 6; k++) r = gf_mul(gf_mul(r, r), x);
        r = gf_mul(r, r);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_ks_word_gen.sv
// Next expanded key word w[i] from the sliding window, rcon and the S-box result.
// Purely combinational, zero latency; no flow control of its own.
// Ports: window (w[i-NK..i-1], oldest in MSBs), i, rcon, sub (SubWord result) -> sbox_in, w.
module aes_ks_word_gen
    import aes_ks_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic [NK-1:0][31:0] window,
    input  logic [5:0]          i,
    input  logic [7:0]          rcon,
    input  logic [31:0]         sub,
    output logic [31:0]         sbox_in,
    output logic [31:0]         w
);

    logic [31:0] prev;
    logic [31:0] oldest;
    logic        rot_pos;
    logic        sub_pos;

    assign prev    = window[0];
    assign oldest  = window[NK-1];
    assign rot_pos = (int'(i) % NK) == 0;
    assign sub_pos = is_sbox_word(int'(i), NK);

    // RotWord only on the rcon positions; the AES-256 mid-group word is SubWord alone.
    assign sbox_in = rot_pos ? {prev[23:0], prev[31:24]} : prev;

    always_comb begin
        w = oldest ^ prev;
        if (sub_pos) w = oldest ^ sub ^ (rot_pos ? {rcon, 24'h0} : 32'h0);
    end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128/192/256 key schedule emitting round keys 0..NR over valid/ready.
// Round 0 valid 5 cycles after start; one word per cycle, two for S-box words.
// A completed group waits while rk_valid && !rk_ready; rk_data/rk_round hold stable.
// Ports: clk, reset_n, start, key -> busy; rk_valid/rk_ready/rk_data/rk_round/rk_last; done;
// replay/reverse re-emit cached keys when built with AES_KS_CACHE_EN (ignored otherwise).
module aes_key_sched
    import aes_ks_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [32*NK-1:0]  key,
    output logic              busy,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [127:0]      rk_data,
    output logic [3:0]        rk_round,
    output logic              rk_last,
    output logic              done,
    input  logic              replay,
    input  logic              reverse
);

    localparam int NR = nr_of(NK);
    localparam int NW = total_words(NK);

    if (!nk_legal(NK)) begin : g_nk_check
        $error("aes_key_sched: NK must be 4, 6 or 8");
    end

    ks_state_t           state, state_n;
    logic [5:0]          i;
    logic [7:0]          rcon;
    logic [NK-1:0][31:0] win;
    logic [2:0][31:0]    col;
    logic [31:0]         sbox_q, sbox_in, gen_w, key_w, new_w;
    logic                hs, group_end, stall, word_wr, last_word, rot_pos;

    assign busy      = (state != S_IDLE);
    assign hs        = rk_valid && rk_ready;
    assign group_end = (i[1:0] == 2'd3);
    // The fourth word of a group needs the output register free (or draining this edge).
    assign stall     = group_end && rk_valid && !rk_ready;
    assign word_wr   = (state inside {S_KEYW, S_GEN, S_SUB_WR}) && !stall;
    assign last_word = (i == 6'(NW - 1));
    assign rot_pos   = (int'(i) % NK) == 0;
    assign new_w     = (state == S_KEYW) ? key_w : gen_w;

    // During KEYW the window still holds the raw key with w0 in the top word.
    always_comb begin
        key_w = 32'h0;
        for (int j = 0; j < NK; j++) begin
            if (i == 6'(j)) key_w = win[NK-1-j];
        end
    end

    aes_ks_word_gen #(.NK(NK)) u_word_gen (
        .window  (win),
        .i       (i),
        .rcon    (rcon),
        .sub     (sbox_q),
        .sbox_in (sbox_in),
        .w       (gen_w)
    );

    // Single shared registered S-box word lookup; held through an output stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            sbox_q <= 32'h0;
        else if (state == S_SUB) sbox_q <= sub_word(sbox_in);
    end

`ifdef AES_KS_CACHE_EN
    logic [127:0] cache [0:NR];
    logic         cache_valid;
    logic         rev_mode;
    logic [3:0]   next_round;

    assign next_round = rev_mode ? rk_round - 4'd1 : rk_round + 4'd1;
    assign rk_last    = rk_valid && (rk_round == (rev_mode ? 4'd0 : 4'(NR)));

    always_ff @(posedge clk) begin
        if (hs && state != S_REPLAY) cache[rk_round] <= rk_data;
    end
`else
    logic unused_inputs;
    assign unused_inputs = replay ^ reverse;
    assign rk_last       = rk_valid && (rk_round == 4'(NR));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_LOAD;
`ifdef AES_KS_CACHE_EN
                else if (replay && cache_valid) state_n = S_REPLAY;
`endif
            end
            S_LOAD: state_n = S_KEYW;
            S_KEYW, S_GEN, S_SUB_WR: begin
                if (word_wr) begin
                    if (last_word) state_n = S_FLUSH;
                    else if (state != S_KEYW || i == 6'(NK - 1))
                        state_n = is_sbox_word(int'(i) + 1, NK) ? S_SUB : S_GEN;
                end
            end
            S_SUB:    state_n = S_SUB_WR;
            S_FLUSH:  if (hs) state_n = S_IDLE;
            S_REPLAY: if (hs && rk_last) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i        <= 6'h0;
            rcon     <= 8'h01;
            win      <= '0;
            col      <= '0;
            rk_data  <= 128'h0;
            rk_round <= 4'h0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
`ifdef AES_KS_CACHE_EN
            cache_valid <= 1'b0;
            rev_mode    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (hs) rk_valid <= 1'b0;
            if (state == S_LOAD) begin
                win  <= key;
                i    <= 6'h0;
                rcon <= 8'h01;
            end
            if (word_wr) begin
                i <= i + 6'd1;
                if (state != S_KEYW) begin
                    win <= {win[NK-2:0], new_w};
                    if (rot_pos) rcon <= xtime(rcon);
                end
                // A completing group bypasses the collector straight into rk_data.
                if (group_end) begin
                    rk_data  <= {col[0], col[1], col[2], new_w};
                    rk_round <= i[5:2];
                    rk_valid <= 1'b1;
                end
                if (i[1:0] == 2'd0) col[0] <= new_w;
                if (i[1:0] == 2'd1) col[1] <= new_w;
                if (i[1:0] == 2'd2) col[2] <= new_w;
            end
            if (state == S_FLUSH && hs) done <= 1'b1;
`ifdef AES_KS_CACHE_EN
            if (state == S_LOAD) rev_mode <= 1'b0;
            if (state == S_IDLE && start) cache_valid <= 1'b0;
            if (state == S_FLUSH && hs) cache_valid <= 1'b1;
            if (state == S_IDLE && !start && replay && cache_valid) begin
                rev_mode <= reverse;
                rk_round <= reverse ? 4'(NR) : 4'd0;
                rk_data  <= cache[reverse ? NR : 0];
                rk_valid <= 1'b1;
            end
            if (state == S_REPLAY && hs) begin
                if (rk_last) done <= 1'b1;
                else begin
                    rk_round <= next_round;
                    rk_data  <= cache[next_round];
                    rk_valid <= 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched with FIPS-197 key vectors for NK = 4, 6, 8.
// Three instances share clock and reset; NK=4 also runs random back-pressure and reset abort.
module tb_aes_key_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic start4 = 1'b0, start68 = 1'b0;
    logic rk_ready4 = 1'b1;
    logic replay = 1'b0, reverse = 1'b0;

    logic [127:0] key4 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    logic [191:0] key6 = 192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b;
    logic [255:0] key8 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

    logic         busy4, rk_valid4, rk_last4, done4;
    logic [127:0] rk_data4;
    logic [3:0]   rk_round4;
    logic         busy6, rk_valid6, rk_last6, done6;
    logic [127:0] rk_data6;
    logic [3:0]   rk_round6;
    logic         busy8, rk_valid8, rk_last8, done8;
    logic [127:0] rk_data8;
    logic [3:0]   rk_round8;

    aes_key_sched #(.NK(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .key(key4), .busy(busy4),
        .rk_valid(rk_valid4), .rk_ready(rk_ready4), .rk_data(rk_data4), .rk_round(rk_round4),
        .rk_last(rk_last4), .done(done4), .replay(replay), .reverse(reverse)
    );
    aes_key_sched #(.NK(6)) u_dut6 (
        .clk(clk), .reset_n(reset_n), .start(start68), .key(key6), .busy(busy6),
        .rk_valid(rk_valid6), .rk_ready(1'b1), .rk_data(rk_data6), .rk_round(rk_round6),
        .rk_last(rk_last6), .done(done6), .replay(1'b0), .reverse(1'b0)
    );
    aes_key_sched #(.NK(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start68), .key(key8), .busy(busy8),
        .rk_valid(rk_valid8), .rk_ready(1'b1), .rk_data(rk_data8), .rk_round(rk_round8),
        .rk_last(rk_last8), .done(done8), .replay(1'b0), .reverse(1'b0)
    );

    // FIPS-197 Appendix A.1 round keys for key4.
    logic [127:0] exp4 [0:10] = '{
        128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
        128'ha0fafe17_88542cb1_23a33939_2a6c7605,
        128'hf2c295f2_7a96b943_5935807a_7359f67f,
        128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
        128'hef44a541_a8525b7f_b671253b_db0bad00,
        128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
        128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
        128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
        128'head27321_b58dbad2_312bf560_7f8d292f,
        128'hac7766f3_19fadc21_28d12941_575c006e,
        128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
    };

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Runs one NK=4 expansion; pct = rk_ready probability in percent,
    // poke = cycle index at which a spurious start is pulsed (-1 for none).
    task automatic run4(input int pct, input int poke, output int nkeys, output int nbad,
                        output int ndone, output int nuns, output int tmo);
        logic [127:0] prev_dat;
        logic [3:0]   prev_rnd;
        logic         prev_stall;
        int           dc;
        nkeys = 0; nbad = 0; ndone = 0; nuns = 0; dc = -1; prev_stall = 1'b0;
        prev_dat = '0; prev_rnd = '0;
        start4 = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (prev_stall && (!rk_valid4 || rk_data4 !== prev_dat || rk_round4 !== prev_rnd))
                nuns++;
            if (done4) begin
                ndone++;
                if (dc < 0) dc = c;
            end
            if (dc >= 0 && c >= dc + 3) break;
            start4    = (c == poke);
            rk_ready4 = ($urandom_range(0, 99) < pct);
            if (rk_valid4 && rk_ready4) begin
                if (nkeys > 10 || rk_round4 !== 4'(nkeys) || rk_data4 !== exp4[nkeys]) nbad++;
                nkeys++;
            end
            prev_stall = rk_valid4 && !rk_ready4;
            prev_dat   = rk_data4;
            prev_rnd   = rk_round4;
        end
        start4    = 1'b0;
        rk_ready4 = 1'b1;
        tmo       = (dc < 0) ? 1 : 0;
    endtask

    initial begin
        int n, d4, d6, d8;
        int nkeys, nbad, ndone, nuns, tmo;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy4, 1'b0);
        check("rst_valid", rk_valid4, 1'b0);
        check("rst_done", done4, 1'b0);
        check("rst_last", rk_last4, 1'b0);
        check("rst_data", rk_data4, 128'h0);
        check("rst_round", rk_round4, 4'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Latency and vectors with rk_ready held high, all three key sizes at once
        start4 = 1'b1; start68 = 1'b1; rk_ready4 = 1'b1;
        n = 0; d4 = 0; d6 = 0; d8 = 0;
        for (int e = 0; e <= 80; e++) begin
            @(posedge clk); #1;
            start4 = 1'b0; start68 = 1'b0;
            if (e == 0)  check("t1_busy", busy4, 1'b1);
            if (e == 4)  check("t1_r0_early", rk_valid4, 1'b0);
            if (e == 5)  begin
                check("t1_r0_valid", rk_valid4, 1'b1);
                check("t1_nk6_r0", rk_data6, key6[191:64]);
                check("t1_nk8_r0", rk_data8, key8[255:128]);
            end
            if (e == 9)  check("t1_nk8_r1", rk_data8, key8[127:0]);
            if (e == 54) check("t1_last_early", rk_last4, 1'b0);
            if (e == 55) begin
                check("t1_last", rk_last4, 1'b1);
                check("t1_last_round", rk_round4, 4'd10);
            end
            if (e == 56) begin
                check("t1_done", done4, 1'b1);
                check("t1_busy_fall", busy4, 1'b0);
            end
            if (e == 60) check("t1_nk6_last_early", rk_last6, 1'b0);
            if (e == 61) begin
                check("t1_nk6_r12", rk_data6, 128'he98ba06f_448c773c_8ecc7204_01002202);
                check("t1_nk6_last", rk_last6, 1'b1);
            end
            if (e == 73) check("t1_nk8_last_early", rk_last8, 1'b0);
            if (e == 74) begin
                check("t1_nk8_r14", rk_data8, 128'hfe4890d1_e6188d0b_046df344_706c631e);
                check("t1_nk8_last", rk_last8, 1'b1);
            end
            if (rk_valid4) begin
                if (n < 11) check($sformatf("t1_rk%0d", n), rk_data4, exp4[n]);
                n++;
            end
            d4 += int'(done4); d6 += int'(done6); d8 += int'(done8);
        end
        check("t1_nkeys", 128'(n), 128'd11);
        check("t1_done4_cnt", 128'(d4), 128'd1);
        check("t1_done6_cnt", 128'(d6), 128'd1);
        check("t1_done8_cnt", 128'(d8), 128'd1);

        // Random back-pressure, 30 percent ready
        run4(30, -1, nkeys, nbad, ndone, nuns, tmo);
        check("t2_timeout", 128'(tmo), 128'd0);
        check("t2_nkeys", 128'(nkeys), 128'd11);
        check("t2_bad_keys", 128'(nbad), 128'd0);
        check("t2_unstable", 128'(nuns), 128'd0);
        check("t2_done_cnt", 128'(ndone), 128'd1);

        // Reset mid-expansion, then restart with a start pulsed while busy
        start4 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            start4 = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("t3_busy", busy4, 1'b0);
        check("t3_valid", rk_valid4, 1'b0);
        check("t3_data", rk_data4, 128'h0);
        check("t3_round", rk_round4, 4'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run4(100, 10, nkeys, nbad, ndone, nuns, tmo);
        check("t3_timeout", 128'(tmo), 128'd0);
        check("t3_nkeys", 128'(nkeys), 128'd11);
        check("t3_bad_keys", 128'(nbad), 128'd0);
        check("t3_done_cnt", 128'(ndone), 128'd1);

`ifdef AES_KS_CACHE_EN
        // Reverse replay from the cache
        replay = 1'b1; reverse = 1'b1; rk_ready4 = 1'b1;
        n = 0; d4 = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            replay = 1'b0; reverse = 1'b0;
            if (c == 0) begin
                check("t4_first_valid", rk_valid4, 1'b1);
                check("t4_first_round", rk_round4, 4'd10);
            end
            if (rk_valid4) begin
                if (n < 11) begin
                    check($sformatf("t4_rk%0d", 10 - n), rk_data4, exp4[10-n]);
                    check($sformatf("t4_last%0d", 10 - n), rk_last4, (n == 10) ? 1'b1 : 1'b0);
                end
                n++;
            end
            d4 += int'(done4);
        end
        check("t4_nkeys", 128'(n), 128'd11);
        check("t4_done_cnt", 128'(d4), 128'd1);
`else
        // Without the cache, replay must be ignored
        replay = 1'b1; reverse = 1'b1;
        @(posedge clk); #1;
        replay = 1'b0; reverse = 1'b0;
        check("t4_replay_busy", busy4, 1'b0);
        check("t4_replay_valid", rk_valid4, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
